beagle_bus_capture: RTL and testbench

//  Receives 16-bit words written by the Beagle over the FX2 expansion pins (async data bus + write strobe),

---
 rtl/beagle_bus_capture_pkg.sv | 19 +
 rtl/bbc_fifo.sv | 75 +++++++
 rtl/beagle_bus_capture.sv | 167 ++++++++++++++++
 tb/tb_beagle_bus_capture.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/beagle_bus_capture_pkg.sv
// Shared constants and types for the Beagle FX2 bus capture block.
package beagle_bus_capture_pkg;

  localparam int unsigned DW                 = 16;
  localparam int unsigned FifoDepthDefault   = 4;
  localparam int unsigned FiltDefault        = 3;
  localparam int unsigned StretchWDefault    = 22;

  localparam logic SEL_DATA  = 1'b0;
  localparam logic SEL_CLEAR = 1'b1;

  typedef enum logic [1:0] {
    StLow,
    StQualHi,
    StHigh,
    StQualLo
  } filt_state_e;

endpackage

// File: rtl/bbc_fifo.sv
// First-word-fall-through sync FIFO with registered head word and flush.
module bbc_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [DW-1:0] dout_o,
  output logic          valid_o,
  output logic          full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          empty, full, do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      dout_d  = '0;
      valid_d = 1'b0;
    end else begin
      wptr_d  = wptr_q + PW'(do_push);
      rptr_d  = rptr_q + PW'(do_pop);
      valid_d = (wptr_d != rptr_d);
      // The new head may be the word being written this cycle; bypass the array.
      if (valid_d) begin
        if (do_push && (rptr_d[AW-1:0] == wptr_q[AW-1:0])) dout_d = din_i;
        else                                              dout_d = mem_q[rptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign full_o  = full;

endmodule

// File: rtl/beagle_bus_capture.sv
// Captures Beagle bus writes: synchronise, de-glitch the strobe, buffer in a FWFT FIFO.
module beagle_bus_capture
  import beagle_bus_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FifoDepthDefault,
  parameter int unsigned FILT       = FiltDefault,
  parameter int unsigned STRETCH_W  = StretchWDefault
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic [DW-1:0] bus_d,
  input  logic          bus_wr,
  input  logic          bus_sel,
  output logic [DW-1:0] num,
  output logic          num_valid,
  input  logic          num_ready,
  output logic          overflow,
  output logic [15:0]   word_count,
  output logic          act_led
);

  localparam int unsigned CntW = $clog2(FILT + 1);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [DW-1:0] d_s1_q, d_s2_q;
  logic          wr_s1_q, wr_s2_q, sel_s1_q, sel_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_s1_q   <= '0;
      d_s2_q   <= '0;
      wr_s1_q  <= 1'b0;
      wr_s2_q  <= 1'b0;
      sel_s1_q <= 1'b0;
      sel_s2_q <= 1'b0;
    end else begin
      d_s1_q   <= bus_d;
      d_s2_q   <= d_s1_q;
      wr_s1_q  <= bus_wr;
      wr_s2_q  <= wr_s1_q;
      sel_s1_q <= bus_sel;
      sel_s2_q <= sel_s1_q;
    end
  end

  filt_state_e     state_q, state_d;
  logic [CntW-1:0] filt_cnt_q, filt_cnt_d;
  logic            capture;

  always_comb begin
    state_d    = state_q;
    filt_cnt_d = filt_cnt_q;
    capture    = 1'b0;
    unique case (state_q)
      StLow: begin
        if (wr_s2_q) begin
          state_d    = StQualHi;
          filt_cnt_d = '0;
        end
      end
      StQualHi: begin
        if (!wr_s2_q) begin
          state_d = StLow;
        end else if (filt_cnt_q == CntW'(FILT)) begin
          state_d = StHigh;
          capture = 1'b1;
        end else begin
          filt_cnt_d = filt_cnt_q + CntW'(1);
        end
      end
      StHigh: begin
        if (!wr_s2_q) begin
          state_d    = StQualLo;
          filt_cnt_d = '0;
        end
      end
      StQualLo: begin
        if (wr_s2_q) begin
          state_d = StHigh;
        end else if (filt_cnt_q == CntW'(FILT)) begin
          state_d = StLow;
        end else begin
          filt_cnt_d = filt_cnt_q + CntW'(1);
        end
      end
      default: state_d = StLow;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLow;
      filt_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  logic                 pop, do_clear, data_evt, push, fifo_full;
  logic                 overflow_q, overflow_d;
  logic [15:0]          word_cnt_q, word_cnt_d;
  logic [STRETCH_W-1:0] stretch_q, stretch_d;

  assign pop      = num_valid && num_ready;
  assign do_clear = capture && (sel_s2_q == SEL_CLEAR);
  assign data_evt = capture && (sel_s2_q == SEL_DATA);
  assign push     = data_evt && (!fifo_full || pop);

  always_comb begin
    overflow_d = overflow_q;
    word_cnt_d = word_cnt_q;
    stretch_d  = stretch_q;
    if (stretch_q != '0) stretch_d = stretch_q - STRETCH_W'(1);
    if (do_clear) begin
      overflow_d = 1'b0;
      word_cnt_d = '0;
    end else if (push) begin
      word_cnt_d = word_cnt_q + 16'd1;
      stretch_d  = '1;
    end else if (data_evt) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      word_cnt_q <= '0;
      stretch_q  <= '0;
    end else begin
      overflow_q <= overflow_d;
      word_cnt_q <= word_cnt_d;
      stretch_q  <= stretch_d;
    end
  end

  // A clear in the same cycle as a pop wins; the pop is dropped.
  bbc_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .din_i   (d_s2_q),
    .pop_i   (pop && !do_clear),
    .flush_i (do_clear),
    .dout_o  (num),
    .valid_o (num_valid),
    .full_o  (fifo_full)
  );

  assign overflow   = overflow_q;
  assign word_count = word_cnt_q;
  assign act_led    = (stretch_q != '0);

endmodule

// File: tb/tb_beagle_bus_capture.sv
// Directed bench for beagle_bus_capture with a queue-based reference model.
module tb_beagle_bus_capture;

  localparam int unsigned Filt       = 3;
  localparam int unsigned Depth      = 4;
  localparam int unsigned StretchMax = (1 << 22) - 1;

  logic        clk = 1'b0;
  logic        nRESET = 1'b0;
  logic [15:0] bus_d = '0;
  logic        bus_wr = 1'b0;
  logic        bus_sel = 1'b0;
  logic        num_ready = 1'b0;
  logic [15:0] num;
  logic        num_valid;
  logic        overflow;
  logic [15:0] word_count;
  logic        act_led;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  beagle_bus_capture dut (
    .clk        (clk),
    .nRESET     (nRESET),
    .bus_d      (bus_d),
    .bus_wr     (bus_wr),
    .bus_sel    (bus_sel),
    .num        (num),
    .num_valid  (num_valid),
    .num_ready  (num_ready),
    .overflow   (overflow),
    .word_count (word_count),
    .act_led    (act_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: filtered level flips after Filt+2 consecutive opposite samples,
  // seen through a two-cycle synchroniser delay; FIFO as a queue.
  logic [15:0]  m_q[$];
  logic [15:0]  m_num, m_cnt;
  bit           m_valid, m_ovf, m_level;
  int unsigned  m_run, m_rcnt, m_stretch;
  logic         m_wr1, m_wr2, m_sel1, m_sel2;
  logic [15:0]  m_d1, m_d2;

  task automatic m_reset();
    m_q.delete();
    m_num = '0; m_cnt = '0; m_valid = 0; m_ovf = 0; m_level = 0;
    m_run = 0; m_rcnt = 0; m_stretch = 0;
    m_wr1 = 0; m_wr2 = 0; m_sel1 = 0; m_sel2 = 0; m_d1 = '0; m_d2 = '0;
  endtask

  task automatic m_step();
    bit pop, cap, flushed;
    pop = m_valid && num_ready;
    cap = 0;
    flushed = 0;
    if (m_wr2 != m_level) begin
      m_run++;
      if (m_run == Filt + 2) begin
        m_level = m_wr2;
        m_run   = 0;
        cap     = m_level;
      end
    end else begin
      m_run = 0;
    end
    if (m_stretch != 0) m_stretch--;
    if (cap && m_sel2) begin
      m_q.delete();
      m_ovf = 0;
      m_cnt = '0;
      flushed = 1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (cap) begin
        if (m_q.size() < Depth) begin
          m_q.push_back(m_d2);
          m_cnt     = m_cnt + 16'd1;
          m_stretch = StretchMax;
        end else begin
          m_ovf = 1;
        end
      end
    end
    m_valid = (m_q.size() > 0);
    if (m_valid)      m_num = m_q[0];
    else if (flushed) m_num = '0;
    m_wr2 = m_wr1; m_wr1 = bus_wr;
    m_sel2 = m_sel1; m_sel1 = bus_sel;
    m_d2 = m_d1; m_d1 = bus_d;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge nRESET);
      if (!nRESET)        m_reset();
      else if (m_rcnt < 2) m_rcnt++;
      else                m_step();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("num_valid", 32'(num_valid), 32'(m_valid));
      chk("num", 32'(num), 32'(m_num));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("word_count", 32'(word_count), 32'(m_cnt));
      chk("act_led", 32'(act_led), 32'(m_stretch != 0));
    end
  end

  task automatic strobe(input logic [15:0] d, input logic sel, input int hi, input int lo);
    @(negedge clk);
    bus_d = d;
    bus_sel = sel;
    @(negedge clk);
    bus_wr = 1'b1;
    repeat (hi) @(negedge clk);
    bus_wr = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    num_ready = 1'b1;
    @(negedge clk);
    num_ready = 1'b0;
  endtask

  initial begin
    // Reset held with the bus toggling.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_wr = ~bus_wr;
      bus_d  = 16'(i * 16'h1111);
      bus_sel = i[0];
    end
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(num_valid), 0);
    chk("rst_count", 32'(word_count), 0);
    chk("rst_led", 32'(act_led), 0);
    bus_wr = 1'b0; bus_sel = 1'b0; bus_d = '0;
    nRESET = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_num", 32'(num), 0);

    // Glitch of Filt+1 cycles is rejected.
    strobe(16'hBEEF, 1'b0, Filt + 1, 8);
    chk("glitch_count", 32'(word_count), 0);
    chk("glitch_valid", 32'(num_valid), 0);

    // Single write: latency pinned at edge Filt+3.
    @(negedge clk);
    bus_d = 16'h1234;
    @(negedge clk);
    bus_wr = 1'b1;
    repeat (Filt + 3) @(negedge clk);
    chk("lat_early", 32'(num_valid), 0);
    @(negedge clk);
    chk("lat_valid", 32'(num_valid), 1);
    chk("lat_num", 32'(num), 32'h1234);
    chk("lat_count", 32'(word_count), 1);
    chk("lat_led", 32'(act_led), 1);
    bus_wr = 1'b0;
    repeat (8) @(negedge clk);
    pop_one();
    chk("pop_valid", 32'(num_valid), 0);
    chk("pop_num_hold", 32'(num), 32'h1234);

    // Overflow: five writes into a four-deep FIFO, last one at the minimum pulse width.
    strobe(16'h0000, 1'b1, 7, 8);
    for (int i = 1; i <= 5; i++) strobe(16'(i), 1'b0, (i == 5) ? Filt + 2 : 7, 8);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(word_count), 4);
    num_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(num), 32'(i));
      @(negedge clk);
    end
    num_ready = 1'b0;
    chk("drain_empty", 32'(num_valid), 0);

    // Pop coinciding with a write on a full FIFO: accepted, no overflow.
    strobe(16'h0000, 1'b1, 7, 8);
    for (int i = 1; i <= 4; i++) strobe(16'(i), 1'b0, 7, 8);
    @(negedge clk);
    bus_d = 16'h0005;
    @(negedge clk);
    bus_wr = 1'b1;
    repeat (Filt + 3) @(negedge clk);
    num_ready = 1'b1;
    @(negedge clk);
    num_ready = 1'b0;
    chk("full_pop_ovf", 32'(overflow), 0);
    chk("full_pop_count", 32'(word_count), 5);
    chk("full_pop_head", 32'(num), 32'h0002);
    @(negedge clk);
    bus_wr = 1'b0;
    repeat (8) @(negedge clk);

    // Clear with three words queued and overflow set.
    strobe(16'h0006, 1'b0, 7, 8);
    pop_one();
    chk("pre_clr_ovf", 32'(overflow), 1);
    strobe(16'hFFFF, 1'b1, 7, 0);
    chk("clr_valid", 32'(num_valid), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_count", 32'(word_count), 0);
    chk("clr_led", 32'(act_led), 1);
    repeat (8) @(negedge clk);

    // Async reset mid-queue.
    strobe(16'h00A1, 1'b0, 7, 8);
    strobe(16'h00A2, 1'b0, 7, 8);
    @(negedge clk);
    #2 nRESET = 1'b0;
    #1;
    chk("arst_valid", 32'(num_valid), 0);
    chk("arst_led", 32'(act_led), 0);
    chk("arst_count", 32'(word_count), 0);
    repeat (3) @(negedge clk);
    nRESET = 1'b1;
    repeat (4) @(negedge clk);
    strobe(16'h5A5A, 1'b0, 7, 8);
    chk("recover_count", 32'(word_count), 1);
    chk("recover_num", 32'(num), 32'h5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
